// File: rtl/maze_mem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the single-port MazeMemory.
// Each accepted request becomes one RD or WR strobe followed by a one-cycle Ack.
module maze_mem_arbiter #(
   parameter int unsigned READ_LAT = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Req0,
   input  logic       Req1,
   input  logic       We0,
   input  logic       We1,
   input  logic [3:0] X0,
   input  logic [3:0] X1,
   input  logic [3:0] Y0,
   input  logic [3:0] Y1,
   input  logic       Wd0,
   input  logic       Wd1,
   input  logic       Lock0,
   input  logic       Lock1,
   output logic       Ack0,
   output logic       Ack1,
   output logic       Rd0,
   output logic       Rd1,
   output logic [1:0] Grant,
   output logic       Busy,
   output logic       RD,
   output logic       WR,
   output logic [3:0] X,
   output logic [3:0] Y,
   output logic       Din,
   input  logic       Dout
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t     state;
   logic       last;
   logic       hold;
   logic       win;
   logic       we_q;
   logic [1:0] cnt;

   logic       pick;
   logic       any_req;
   logic       last_req;
   logic       win_lock;
   logic       win_req;

   always_comb begin
      any_req  = Req0 | Req1;
      last_req = last ? Req1 : Req0;
      win_lock = win ? Lock1 : Lock0;
      win_req  = win ? Req1 : Req0;
      pick     = 1'b0;
      if (Req0 && Req1)
         pick = hold ? last : ~last;
      else if (Req1)
         pick = 1'b1;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
         last  <= 1'b1;
         hold  <= 1'b0;
         win   <= 1'b0;
         we_q  <= 1'b0;
         cnt   <= '0;
         Grant <= '0;
         Ack0  <= 1'b0;
         Ack1  <= 1'b0;
         Busy  <= 1'b0;
         RD    <= 1'b0;
         WR    <= 1'b0;
         X     <= '0;
         Y     <= '0;
         Din   <= 1'b0;
         Rd0   <= 1'b0;
         Rd1   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (hold && !last_req)
                  hold <= 1'b0;
               if (any_req) begin
                  // X/Y/Din registered here double as the request latches
                  win   <= pick;
                  we_q  <= pick ? We1 : We0;
                  X     <= pick ? X1 : X0;
                  Y     <= pick ? Y1 : Y0;
                  Din   <= pick ? Wd1 : Wd0;
                  WR    <= pick ? We1 : We0;
                  RD    <= pick ? ~We1 : ~We0;
                  Grant <= pick ? 2'b10 : 2'b01;
                  Busy  <= 1'b1;
                  if (pick != last)
                     hold <= 1'b0;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               RD <= 1'b0;
               WR <= 1'b0;
               if (we_q) begin
                  if (win) Ack1 <= 1'b1; else Ack0 <= 1'b1;
                  state <= ACK;
               end else begin
                  cnt <= 2'(READ_LAT - 1);
                  if (READ_LAT == 1) begin
                     if (win) Rd1 <= Dout; else Rd0 <= Dout;
                     if (win) Ack1 <= 1'b1; else Ack0 <= 1'b1;
                     state <= ACK;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt <= 2'd1) begin
                  cnt <= '0;
                  if (win) Rd1 <= Dout; else Rd0 <= Dout;
                  if (win) Ack1 <= 1'b1; else Ack0 <= 1'b1;
                  state <= ACK;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            ACK: begin
               Ack0  <= 1'b0;
               Ack1  <= 1'b0;
               last  <= win;
               hold  <= win_lock & win_req;
               Grant <= '0;
               Busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/maze_mem_arbiter.md
# maze_mem_arbiter

Two-requester arbiter and sequencer for the single-port MazeMemory (ports Din, RD, WR, X, Y, Dout). It lets the intelligent_rat search controller (requester 0) share the maze store with a maze loader / path-replay unit (requester 1) without bus contention. Each accepted request becomes exactly one RD or WR strobe, and the arbiter returns a one-cycle acknowledge. Arbitration is round-robin, and a lock input lets a requester keep consecutive transactions.

## Interface
- READ_LAT, 1, cycles from the RD strobe to valid Dout (range 1..3)
- CLK  in  1  system clock; all state changes on the rising edge
- RST  in  1  asynchronous, active-low reset
- Req0, Req1  in  1  transaction request; held high until the matching Ack
- We0, We1  in  1  1 = write, 0 = read; stable while Req is high
- X0, X1, Y0, Y1  in  4  cell coordinate; stable while Req is high
- Wd0, Wd1  in  1  write data bit; stable while Req is high
- Lock0, Lock1  in  1  sampled in ACK; keeps the grant for the next transaction
- Ack0, Ack1  out  1  one-cycle completion pulse
- Rd0, Rd1  out  1  registered read data; valid from Ack until that requester's next Ack
- Grant  out  2  one-hot current owner; 00 when idle
- Busy  out  1  high in every state except IDLE
- RD, WR  out  1  memory strobes, never high together
- X, Y  out  4  memory coordinate
- Din  out  1  memory write data
- Dout  in  1  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE (Grant = 00):
  - If no Req is high, stay in IDLE.
  - If exactly one Req is high, grant it.
  - If both are high, grant the requester other than `last`, except when `hold` is set; then grant `last`.
  - On a grant, latch We/X/Y/Wd of the winner, set Grant, and go to ISSUE.
- ISSUE (one cycle): drive X/Y/Din from the latches.
  - Write: assert WR, then go to ACK.
  - Read: assert RD and load a wait counter with READ_LAT-1.
    - If READ_LAT = 1, go directly to ACK and sample Dout on the ACK entry edge.
    - Otherwise go to WAIT.
- WAIT: decrement the counter. X and Y stay driven and RD stays low. When the counter reaches 0, sample Dout into the winner's Rd register and go to ACK.
- ACK (one cycle):
  - Pulse the winner's Ack and set `last` to the winner.
  - Set `hold` = winner's Lock AND winner's Req, sampled in this cycle.
  - Go to IDLE.
- Requester protocol: drop Req in the cycle after Ack, or keep it high to start a new transaction. Any high Req seen in IDLE is a new transaction.
- `hold` is cleared whenever the other requester wins, or when the held requester has no Req in IDLE. If Lock stays high, the other requester can starve; that is allowed and is the requester's responsibility.
- X, Y and Din hold their last driven values while idle. RD and WR are low outside ISSUE.
- Rd0 and Rd1 do not change on writes or on the other requester's transactions.

## Timing
- Reset (RST low, asynchronous):
  - State IDLE; Grant, Ack0/1, Busy, RD, WR, X, Y, Din, Rd0, Rd1 all 0.
  - `last` = 1, so requester 0 wins the first tie; `hold` = 0.
- Reset asserted mid-transaction: RD/WR drop immediately, no Ack is issued, and the transaction is lost.
- Write latency: 2 cycles from Req sampled in IDLE to Ack (edge 1 enters ISSUE, edge 2 enters ACK). Back-to-back writes from one requester take 3 cycles each.
- Read latency: READ_LAT+1 cycles from Req sampled to Ack. Rd is updated on the same edge that asserts Ack.
- Simultaneous Req0 and Req1 in IDLE are resolved in a single cycle; the loser's Req stays pending and wins the next IDLE.
- Busy = 1 from the ISSUE entry edge through the ACK cycle.
- Ack never fires for a requester that is not granted. Grant changes only on IDLE exit and ACK exit.

## Test plan
- Reset then idle: RST low at t = 5 ns, high at 10 ns, no Req → all outputs 0 and Grant = 00 for 20 cycles.
- Single write then read, requester 0: write X0 = 3, Y0 = 5, Wd0 = 1 → WR high for exactly 1 cycle with X = 3, Y = 5, and Ack0 two cycles after Req. Read back the same cell → Rd0 = 1 at Ack0, READ_LAT+1 cycles after Req.
- Contention: Req0 and Req1 rise on the same edge after reset → requester 0 is served first, requester 1 next, with no overlapping strobes. Held for 4 transactions → grants alternate 0, 1, 0, 1.
- Lock: Lock1 = 1 with both Reqs high → requester 1 is served 3 times in a row. Drop Lock1 → requester 0 is served next.
- READ_LAT = 3: a read of a cell preloaded with 1 → RD pulses once, Ack 4 cycles after Req, and Rd equals Dout sampled 3 cycles after RD.
- Reset during WAIT (READ_LAT = 3) → RD/WR/Ack/Grant are 0 immediately. A new Req after release completes normally.
